// File: rtl/pcs_synchronization.sv
// 1000BASE-X receive synchronization: comma detection, code-group alignment and
// even/odd tracking, with a one-cycle registered copy of each incoming group.
module pcs_synchronization (
  input  logic       gtx_clk,
  input  logic       mr_main_reset,
  input  logic [9:0] rx_code_group,
  output logic [9:0] sync_code_group,
  output logic       rx_even,
  output logic       code_sync_status,
  output logic [3:0] sync_state
);

  localparam logic [3:0] StLossOfSync   = 4'b0001;
  localparam logic [3:0] StCommaDetect  = 4'b0010;
  localparam logic [3:0] StAcquireSync  = 4'b0100;
  localparam logic [3:0] StSyncAcquired = 4'b1000;

  logic [3:0] state_q, state_d;
  logic [9:0] cg_q, cg_d;
  logic       even_q, even_d;
  logic       status_q, status_d;
  logic [1:0] comma_cnt_q, comma_cnt_d;
  logic [1:0] bad_cnt_q, bad_cnt_d;
  logic [1:0] good_cnt_q, good_cnt_d;

  logic [3:0] ones_all;
  logic [2:0] ones_hi;
  logic [2:0] ones_lo;
  logic       is_comma;
  logic       is_valid;
  logic       is_data;
  logic       cg_bad;

  always_comb begin
    ones_hi = '0;
    ones_lo = '0;
    for (int i = 4; i < 10; i++) ones_hi = ones_hi + {2'b00, rx_code_group[i]};
    for (int i = 0; i < 4; i++)  ones_lo = ones_lo + {2'b00, rx_code_group[i]};
    ones_all = {1'b0, ones_hi} + {1'b0, ones_lo};
  end

  assign is_comma = (rx_code_group[9:3] == 7'b0011111) || (rx_code_group[9:3] == 7'b1100000);
  assign is_valid = (ones_all >= 4'd4) && (ones_all <= 4'd6) &&
                    (ones_hi  >= 3'd2) && (ones_hi  <= 3'd4) &&
                    (ones_lo  >= 3'd1) && (ones_lo  <= 3'd3);
  assign is_data  = is_valid && !is_comma;
  // A comma sampled while the current position is even would itself land odd.
  assign cg_bad   = !is_valid || (is_comma && even_q);

  always_comb begin
    state_d     = state_q;
    cg_d        = rx_code_group;
    even_d      = ~even_q;
    status_d    = status_q;
    comma_cnt_d = comma_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    good_cnt_d  = good_cnt_q;

    case (state_q)
      StLossOfSync: begin
        if (is_comma) begin
          state_d     = StCommaDetect;
          comma_cnt_d = 2'd1;
          even_d      = 1'b1;
        end
      end

      StCommaDetect: begin
        even_d = 1'b0;
        if (is_data && (comma_cnt_q == 2'd3)) begin
          state_d    = StSyncAcquired;
          status_d   = 1'b1;
          bad_cnt_d  = 2'd0;
          good_cnt_d = 2'd0;
        end else if (is_data) begin
          state_d = StAcquireSync;
        end else begin
          state_d     = StLossOfSync;
          comma_cnt_d = 2'd0;
        end
      end

      StAcquireSync: begin
        if (!is_valid || (is_comma && even_q)) begin
          state_d     = StLossOfSync;
          comma_cnt_d = 2'd0;
        end else if (is_comma) begin
          state_d = StCommaDetect;
          even_d  = 1'b1;
          if (comma_cnt_q != 2'd3) comma_cnt_d = comma_cnt_q + 2'd1;
        end
      end

      StSyncAcquired: begin
        if (cg_bad) begin
          good_cnt_d = 2'd0;
          if (bad_cnt_q == 2'd3) begin
            state_d     = StLossOfSync;
            status_d    = 1'b0;
            comma_cnt_d = 2'd0;
            bad_cnt_d   = 2'd0;
          end else begin
            bad_cnt_d = bad_cnt_q + 2'd1;
          end
        end else if (bad_cnt_q != 2'd0) begin
          // Four consecutive good groups retire one bad group.
          if (good_cnt_q == 2'd3) begin
            bad_cnt_d  = bad_cnt_q - 2'd1;
            good_cnt_d = 2'd0;
          end else begin
            good_cnt_d = good_cnt_q + 2'd1;
          end
        end
      end

      default: begin
        state_d     = StLossOfSync;
        even_d      = 1'b0;
        status_d    = 1'b0;
        comma_cnt_d = 2'd0;
        bad_cnt_d   = 2'd0;
        good_cnt_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge gtx_clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q     <= StLossOfSync;
      cg_q        <= '0;
      even_q      <= 1'b0;
      status_q    <= 1'b0;
      comma_cnt_q <= 2'd0;
      bad_cnt_q   <= 2'd0;
      good_cnt_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      cg_q        <= cg_d;
      even_q      <= even_d;
      status_q    <= status_d;
      comma_cnt_q <= comma_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      good_cnt_q  <= good_cnt_d;
    end
  end

  assign sync_code_group  = cg_q;
  assign rx_even          = even_q;
  assign code_sync_status = status_q;
  assign sync_state       = state_q;

endmodule

// File: tb/tb_pcs_synchronization.sv
// Directed bench for pcs_synchronization: each driven group queues its expected
// registered outputs, which are popped and compared one cycle later.
module tb_pcs_synchronization;

  localparam logic [9:0] K   = 10'b0011111010;  // K28.5-
  localparam logic [9:0] KP  = 10'b1100000101;  // K28.5+
  localparam logic [9:0] D   = 10'b0110110101;  // D16.2-
  localparam logic [9:0] DP  = 10'b1001000101;  // D16.2+
  localparam logic [9:0] BAD = 10'b1111111111;
  localparam logic [9:0] Z   = 10'b0000000000;

  localparam logic [3:0] LOS = 4'b0001;
  localparam logic [3:0] CD  = 4'b0010;
  localparam logic [3:0] AS  = 4'b0100;
  localparam logic [3:0] SA  = 4'b1000;

  typedef struct packed {
    logic [9:0] cg;
    logic [3:0] st;
    logic       ev;
    logic       stat;
  } exp_t;

  logic       gtx_clk;
  logic       mr_main_reset;
  logic [9:0] rx_code_group;
  logic [9:0] sync_code_group;
  logic       rx_even;
  logic       code_sync_status;
  logic [3:0] sync_state;

  exp_t exp_q[$];
  int   n_err;
  int   n_checks;

  logic [9:0] data_tbl [0:4];

  pcs_synchronization dut (
    .gtx_clk          (gtx_clk),
    .mr_main_reset    (mr_main_reset),
    .rx_code_group    (rx_code_group),
    .sync_code_group  (sync_code_group),
    .rx_even          (rx_even),
    .code_sync_status (code_sync_status),
    .sync_state       (sync_state)
  );

  initial gtx_clk = 1'b0;
  always #5 gtx_clk = ~gtx_clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".cg"},     sync_code_group, 10'd0);
    chk({tag, ".even"},   {9'd0, rx_even}, 10'd0);
    chk({tag, ".status"}, {9'd0, code_sync_status}, 10'd0);
    chk({tag, ".state"},  {6'd0, sync_state}, {6'd0, LOS});
  endtask

  // Drive one group, queue its expected outputs, then compare after the edge.
  task automatic send(input logic [9:0] cg, input logic [3:0] st, input logic ev,
                      input logic stat);
    exp_t e;
    rx_code_group = cg;
    exp_q.push_back('{cg: cg, st: st, ev: ev, stat: stat});
    @(posedge gtx_clk);
    #1;
    n_checks++;
    assert (exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("cg",     sync_code_group, e.cg);
      chk("even",   {9'd0, rx_even}, {9'd0, e.ev});
      chk("status", {9'd0, code_sync_status}, {9'd0, e.stat});
      chk("state",  {6'd0, sync_state}, {6'd0, e.st});
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic pulse_reset(input string tag);
    #3;
    mr_main_reset = 1'b0;
    #1;
    chk_reset_outputs(tag);
    #2;
    mr_main_reset = 1'b1;
  endtask

  task automatic acquire_from_los();
    send(K, CD, 1'b1, 1'b0);
    send(D, AS, 1'b0, 1'b0);
    send(K, CD, 1'b1, 1'b0);
    send(D, AS, 1'b0, 1'b0);
    send(K, CD, 1'b1, 1'b0);
    send(D, SA, 1'b0, 1'b1);
  endtask

  initial begin
    logic       ev;
    logic [9:0] cg;
    n_err    = 0;
    n_checks = 0;
    data_tbl[0] = D;
    data_tbl[1] = DP;
    data_tbl[2] = 10'b1010101010;  // D21.5
    data_tbl[3] = 10'b1001110100;  // D0.0-
    data_tbl[4] = 10'b0110001011;  // D0.0+

    mr_main_reset = 1'b0;
    rx_code_group = 10'd0;
    #12;
    chk_reset_outputs("por");
    mr_main_reset = 1'b1;

    // Acquisition, then reset while in sync.
    acquire_from_los();
    pulse_reset("rst_in_sync");

    // Misaligned comma in ACQUIRE_SYNC, idle toggle in LOSS_OF_SYNC, fresh re-acquire.
    send(K, CD,  1'b1, 1'b0);
    send(D, AS,  1'b0, 1'b0);
    send(D, AS,  1'b1, 1'b0);
    send(K, LOS, 1'b0, 1'b0);
    send(D, LOS, 1'b1, 1'b0);
    acquire_from_los();

    // Hysteresis: 3 bad, 4 good cancel one, 1 bad holds, next bad loses.
    send(BAD, SA,  1'b1, 1'b1);
    send(BAD, SA,  1'b0, 1'b1);
    send(BAD, SA,  1'b1, 1'b1);
    send(DP,  SA,  1'b0, 1'b1);
    send(DP,  SA,  1'b1, 1'b1);
    send(DP,  SA,  1'b0, 1'b1);
    send(DP,  SA,  1'b1, 1'b1);
    send(BAD, SA,  1'b0, 1'b1);
    send(BAD, LOS, 1'b1, 1'b0);
    acquire_from_los();

    // Loss on 4 zero groups, then recovery.
    send(Z, SA,  1'b1, 1'b1);
    send(Z, SA,  1'b0, 1'b1);
    send(Z, SA,  1'b1, 1'b1);
    send(Z, LOS, 1'b0, 1'b0);
    acquire_from_los();

    // Classification boundaries: even comma good, odd comma bad, nibble-rule failures.
    send(K,            SA,  1'b1, 1'b1);
    send(K,            SA,  1'b0, 1'b1);
    send(10'b1111000000, SA,  1'b1, 1'b1);
    send(10'b0011001111, SA,  1'b0, 1'b1);
    send(10'b1111000001, SA,  1'b1, 1'b1);
    send(BAD,          LOS, 1'b0, 1'b0);

    // COMMA_DETECT and ACQUIRE_SYNC fall-back paths.
    send(K,   CD,  1'b1, 1'b0);
    send(K,   LOS, 1'b0, 1'b0);
    send(KP,  CD,  1'b1, 1'b0);
    send(BAD, LOS, 1'b0, 1'b0);
    send(K,   CD,  1'b1, 1'b0);
    send(D,   AS,  1'b0, 1'b0);
    send(BAD, LOS, 1'b1, 1'b0);
    acquire_from_los();

    // Random valid stream in sync; commas only where they land even.
    ev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!ev && ($urandom_range(0, 3) == 0)) cg = ($urandom_range(0, 1) == 0) ? K : KP;
      else cg = data_tbl[$urandom_range(0, 4)];
      ev = ~ev;
      send(cg, SA, ev, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
